// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the tx and rx paths: state encoding,
// baud divisor rounding and a clog2 helper usable in localparams.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Minimum of 1 so a counter for n <= 2 still has a legal width.
  function automatic int uart_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int uart_div(input int clock, input int baud);
    return (clock + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick pulses for one clock every DIV clocks; restart
// holds the count at zero so the first period after release is a full DIV.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLOCK    = 99000000,
  parameter int BAUDRATE = 9600
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart,
  output logic tick
);

  localparam int DIV = uart_div(CLOCK, BAUDRATE);
  localparam int CW  = uart_clog2(DIV);
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == TC)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = !restart && (cnt_q == TC);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: rdy/ack byte source in, LSB-first framed serial line out.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
//   state     | meaning
//   ST_IDLE   | line high, waiting for tx_rdy && tx_enable
//   ST_START  | start bit (low)
//   ST_DATA   | WIDTH data bits, LSB first
//   ST_PARITY | parity of the latched byte (parity builds only)
//   ST_STOP   | STOP_BITS high bits; may accept the next byte on its last clock
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLOCK      = 99000000,
  parameter int BAUDRATE   = 9600,
  parameter int WIDTH      = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_rdy,
  output logic             tx_ack,
  input  logic             tx_enable,
  output logic             tx,
  output logic             tx_busy
);

  localparam int BW = uart_clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e      state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_q;
  logic             tx_q, ack_q, busy_q;
  logic             tick, take, baud_restart;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  // Accept from idle, or on the final stop clock for gapless back-to-back frames.
  assign take = tx_rdy && tx_enable &&
                ((state_q == ST_IDLE) ||
                 ((state_q == ST_STOP) && tick && (bit_q == LAST_STOP)));

  assign baud_restart = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLOCK    (CLOCK),
    .BAUDRATE (BAUDRATE)
  ) u_baud (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .restart (baud_restart),
    .tick    (tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      if (take) begin
        state_q <= ST_START;
        shift_q <= tx_data;
        bit_q   <= '0;
        tx_q    <= 1'b0;
        ack_q   <= 1'b1;
        busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
        par_q   <= (^tx_data) ^ PARITY_ODD;
`endif
      end else if (tick) begin
        case (state_q)
          ST_START: begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
          ST_DATA: begin
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= par_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
`endif
          ST_STOP: begin
            if (bit_q == LAST_STOP) begin
              state_q <= ST_IDLE;
              bit_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              bit_q   <= bit_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx      = tx_q;
  assign tx_ack  = ack_q;
  assign tx_busy = busy_q;

endmodule
